game_sequencer: RTL and testbench
=================================

# game_sequencer

Game controller that drives the four-digit seven-segment display block. It generates the scrolling arrow queue from a pseudo-random source, advances the queue on each metronome beat, and judges the player's button presses against the target arrow. It also maintains score and combo counters and sequences the GAME/PAUSE/RESET states that the display uses to select arrows, score or combo.

## Interface
Parameters:
- RANDOM_BITS, 6: LFSR width.
- LFSR_SEED, 6'b101101: LFSR value loaded at reset; must be non-zero.
- SCORE_MAX, 9999: saturation limit for score and combo (4 decimal digits).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- metronome_clk  in  1  slow beat square wave, asynchronous to clk.
- btn  in  4  debounced single-cycle press pulses {right, left, down, up}.
- pause_req  in  1  single-cycle pulse; toggles GAME/PAUSE.
- reset_req  in  1  single-cycle pulse; restarts the game.
- state  out  2  GAME=0, PAUSE=1, RESET=2.
- cur_arrow0..cur_arrow3  out  5 each  arrow codes 10..20; cur_arrow3 is the target.
- score  out  14  hit count, 0..SCORE_MAX.
- combo_count  out  14  consecutive hits, 0..SCORE_MAX.
- combo_enable  out  1  in PAUSE: 1 shows combo, 0 shows score.

## Operation
- Reset (rst_n low): state=RESET, all cur_arrow=20 (NONE), score=0, combo_count=0, combo_enable=0, press mask=0, LFSR=LFSR_SEED, synchronizer flops=0.
- RESET lasts exactly one cycle, then goes to GAME. reset_req in GAME or PAUSE enters RESET and clears everything as rst_n does, except the LFSR, which keeps running.
- Beat: metronome_clk passes through a 2-flop synchronizer. A rising-edge detect produces a one-cycle beat pulse.
- GAME, press mask: OR-accumulates btn every cycle and clears on beat. A btn pulse in the same cycle as the beat counts toward the window being closed.
- GAME, on beat:
  - Judge cur_arrow3. Required mask is the bit-OR of its component directions (e.g. 15 = UP|LEFT = 4'b0101).
  - If cur_arrow3==20, no judgement is made.
  - Hit means the mask exactly equals the required mask. On a hit, score+1 and combo_count+1, both saturating at SCORE_MAX.
  - Any other mask is a miss, including an extra or missing direction. On a miss, combo_count=0 and score is held.
  - Shift the queue: arrow3←arrow2←arrow1←arrow0←new. The LFSR steps once per beat.
- New arrow = 10 + (lfsr mod N), where N is set by the configuration macro.
- PAUSE:
  - Arrows and score are frozen and beats are ignored.
  - Any btn pulse toggles combo_enable.
  - On entry, the mask is cleared. On exit, combo_enable=0.
- Simultaneous events:
  - reset_req beats pause_req and beat.
  - beat together with pause_req in GAME: judge and shift, then enter PAUSE.
  - pause_req in RESET is ignored.

## Timing
- All outputs are registered; no combinational paths from inputs to outputs.
- metronome_clk rise → beat pulse 3 clk edges later. Judge and shift results are visible at the next edge, so latency is 4 cycles total.
- btn → mask: 1 cycle.
- pause_req → state change: 1 cycle.
- reset_req → state=RESET: 1 cycle, then GAME on the following edge.
- One judgement per beat. At most one LFSR step per beat.
- The first three beats after reset judge NONE, so score and combo are unchanged.

## Configuration
- DOUBLE_ARROW_EN defined: N=10, producing codes 10..19, which include the two-direction arrows.
- DOUBLE_ARROW_EN undefined: N=4, producing codes 10..13 only, single direction.
- Judging logic is identical in both builds.

## Structure
- Shared package game_pkg holds:
  - state codes and STATE_BITS;
  - arrow codes ARROW_UP..ARROW_NONE and NUM_ARROWS;
  - the arrow-to-direction-mask decode function;
  - SCORE_MAX.
  The display block uses the same package.
- Sub-module lfsr_random: Fibonacci LFSR of RANDOM_BITS width with step enable, async active-low reset to the seed, and a registered output.

## Test plan
- Reset, then 4 beats with no presses → arrows 20,20,20 shift out, score=0, combo=0, then arrow3 = first LFSR-derived code.
- cur_arrow3=10, press btn=4'b0001 mid-window, then beat → score 0→1, combo 0→1. The next arrow with no press → combo=0, score=1.
- DOUBLE_ARROW_EN, cur_arrow3=15, press up then left in separate cycles → hit. Press up only → miss, combo=0.
- Force score=9999 and combo=9999 via a hit sequence, then one more hit → both stay 9999.
- pause_req → state=1 and beats freeze the arrows. btn pulse → combo_enable=1, a second pulse → 0. pause_req → state=0, combo_enable=0.
- reset_req in the same cycle as beat and pause_req → state=2 for 1 cycle, then 0. All counters are 0 and arrows are 20.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state codes, arrow codes and the arrow-to-direction decode used by
// the game sequencer and the seven-segment display block.
package game_pkg;

  localparam int STATE_BITS = 2;

  typedef enum logic [STATE_BITS-1:0] {
    ST_GAME  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RESET = 2'd2
  } game_state_t;

  localparam int ARROW_BITS = 5;
  localparam int NUM_ARROWS = 10;

  localparam logic [ARROW_BITS-1:0] ARROW_UP         = 5'd10;
  localparam logic [ARROW_BITS-1:0] ARROW_DOWN       = 5'd11;
  localparam logic [ARROW_BITS-1:0] ARROW_LEFT       = 5'd12;
  localparam logic [ARROW_BITS-1:0] ARROW_RIGHT      = 5'd13;
  localparam logic [ARROW_BITS-1:0] ARROW_UP_DOWN    = 5'd14;
  localparam logic [ARROW_BITS-1:0] ARROW_UP_LEFT    = 5'd15;
  localparam logic [ARROW_BITS-1:0] ARROW_UP_RIGHT   = 5'd16;
  localparam logic [ARROW_BITS-1:0] ARROW_DOWN_LEFT  = 5'd17;
  localparam logic [ARROW_BITS-1:0] ARROW_DOWN_RIGHT = 5'd18;
  localparam logic [ARROW_BITS-1:0] ARROW_LEFT_RIGHT = 5'd19;
  localparam logic [ARROW_BITS-1:0] ARROW_NONE       = 5'd20;

  localparam int SCORE_MAX = 9999;

  // Button bit order is {right, left, down, up}.
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  function automatic logic [3:0] arrow_dir_mask(input logic [ARROW_BITS-1:0] arrow);
    logic [3:0] m;
    m = 4'b0000;
    case (arrow)
      ARROW_UP:         m = DIR_UP;
      ARROW_DOWN:       m = DIR_DOWN;
      ARROW_LEFT:       m = DIR_LEFT;
      ARROW_RIGHT:      m = DIR_RIGHT;
      ARROW_UP_DOWN:    m = DIR_UP | DIR_DOWN;
      ARROW_UP_LEFT:    m = DIR_UP | DIR_LEFT;
      ARROW_UP_RIGHT:   m = DIR_UP | DIR_RIGHT;
      ARROW_DOWN_LEFT:  m = DIR_DOWN | DIR_LEFT;
      ARROW_DOWN_RIGHT: m = DIR_DOWN | DIR_RIGHT;
      ARROW_LEFT_RIGHT: m = DIR_LEFT | DIR_RIGHT;
      default:          m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_random.sv
// Fibonacci LFSR with step enable; the state register is the output.
// Feedback x^W + x^(W-1) + 1 is maximal-length for the 6-bit default.
module lfsr_random #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] SEED  = 6'b101101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  logic feedback;
  assign feedback = value[WIDTH-1] ^ value[WIDTH-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (step) begin
      value <= {value[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Arrow-queue game controller: beat sync, press judging, score/combo and GAME/PAUSE/RESET.
// DOUBLE_ARROW_EN adds the two-direction arrows (codes 14..19) to the random arrow source.
module game_sequencer #(
  parameter int                     RANDOM_BITS = 6,
  parameter logic [RANDOM_BITS-1:0] LFSR_SEED   = 6'b101101,
  parameter int                     SCORE_MAX   = game_pkg::SCORE_MAX
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            metronome_clk,
  input  logic [3:0]                      btn,
  input  logic                            pause_req,
  input  logic                            reset_req,
  output logic [game_pkg::STATE_BITS-1:0] state,
  output logic [4:0]                      cur_arrow0,
  output logic [4:0]                      cur_arrow1,
  output logic [4:0]                      cur_arrow2,
  output logic [4:0]                      cur_arrow3,
  output logic [13:0]                     score,
  output logic [13:0]                     combo_count,
  output logic                            combo_enable
);
  import game_pkg::*;

`ifdef DOUBLE_ARROW_EN
  localparam int ARROW_SPAN = 10;
`else
  localparam int ARROW_SPAN = 4;
`endif

  localparam logic [13:0] SCORE_LIM = 14'(SCORE_MAX);

  game_state_t state_q, state_d;

  logic [2:0]             meter_sync;
  logic                   beat;
  logic [3:0]             press_mask;
  logic [RANDOM_BITS-1:0] lfsr_value;
  logic [4:0]             new_arrow;
  logic                   hit;
  logic                   lfsr_step;

  assign state     = state_q;
  assign new_arrow = ARROW_UP + 5'(int'(lfsr_value) % ARROW_SPAN);
  // A press landing in the beat cycle still belongs to the closing window.
  assign hit       = ((press_mask | btn) == arrow_dir_mask(cur_arrow3));
  assign lfsr_step = (state_q == ST_GAME) && beat && !reset_req;

  lfsr_random #(
    .WIDTH (RANDOM_BITS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (reset_req) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: state_d = ST_GAME;
        ST_GAME:  if (pause_req) state_d = ST_PAUSE;
        ST_PAUSE: if (pause_req) state_d = ST_GAME;
        default:  state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meter_sync   <= '0;
      beat         <= 1'b0;
      press_mask   <= '0;
      cur_arrow0   <= ARROW_NONE;
      cur_arrow1   <= ARROW_NONE;
      cur_arrow2   <= ARROW_NONE;
      cur_arrow3   <= ARROW_NONE;
      score        <= '0;
      combo_count  <= '0;
      combo_enable <= 1'b0;
    end else begin
      // [0],[1] synchronize the beat square wave; [2] is the edge-detect history.
      meter_sync <= {meter_sync[1:0], metronome_clk};
      beat       <= meter_sync[1] & ~meter_sync[2];

      if (reset_req) begin
        press_mask   <= '0;
        cur_arrow0   <= ARROW_NONE;
        cur_arrow1   <= ARROW_NONE;
        cur_arrow2   <= ARROW_NONE;
        cur_arrow3   <= ARROW_NONE;
        score        <= '0;
        combo_count  <= '0;
        combo_enable <= 1'b0;
      end else begin
        case (state_q)
          ST_GAME: begin
            if (beat) begin
              if (cur_arrow3 != ARROW_NONE) begin
                if (hit) begin
                  if (score < SCORE_LIM)       score       <= score + 14'd1;
                  if (combo_count < SCORE_LIM) combo_count <= combo_count + 14'd1;
                end else begin
                  combo_count <= '0;
                end
              end
              cur_arrow3 <= cur_arrow2;
              cur_arrow2 <= cur_arrow1;
              cur_arrow1 <= cur_arrow0;
              cur_arrow0 <= new_arrow;
              press_mask <= '0;
            end else if (pause_req) begin
              press_mask <= '0;
            end else begin
              press_mask <= press_mask | btn;
            end
          end
          ST_PAUSE: begin
            if (pause_req) begin
              combo_enable <= 1'b0;
            end else if (|btn) begin
              combo_enable <= ~combo_enable;
            end
          end
          default: begin
            press_mask <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: reset, beat/judge timing, hit/miss rules,
// pause/combo display toggling, reset priority and score/combo saturation.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        metronome_clk = 1'b0;
  logic [3:0]  btn = 4'b0000;
  logic        pause_req = 1'b0;
  logic        reset_req = 1'b0;
  logic [1:0]  state;
  logic [4:0]  a0, a1, a2, a3;
  logic [13:0] score, combo_count;
  logic        combo_enable;

  int          checks = 0;
  int          failures = 0;
  int          hits = 0;
  int          exp_a3 = 0;
  int          exp_score = 0;
  logic [3:0]  p = 4'b0000;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .metronome_clk (metronome_clk),
    .btn           (btn),
    .pause_req     (pause_req),
    .reset_req     (reset_req),
    .state         (state),
    .cur_arrow0    (a0),
    .cur_arrow1    (a1),
    .cur_arrow2    (a2),
    .cur_arrow3    (a3),
    .score         (score),
    .combo_count   (combo_count),
    .combo_enable  (combo_enable)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 4-clock metronome period. p0/p1 are pressed in the first two cycles,
  // pb in the cycle where the beat pulse is high; judgement lands on the last edge.
  task automatic beat(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] pb);
    metronome_clk = 1'b1; btn = p0; tick();
    btn = p1; tick();
    metronome_clk = 1'b0; btn = 4'b0000; tick();
    btn = pb; tick();
    btn = 4'b0000;
  endtask

  function automatic logic [3:0] tb_dir(input logic [4:0] a);
    case (a)
      5'd10: return 4'b0001;
      5'd11: return 4'b0010;
      5'd12: return 4'b0100;
      5'd13: return 4'b1000;
      5'd14: return 4'b0011;
      5'd15: return 4'b0101;
      5'd16: return 4'b1001;
      5'd17: return 4'b0110;
      5'd18: return 4'b1010;
      5'd19: return 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, 2);
    check_eq("rst_a0", a0, 20);
    check_eq("rst_a3", a3, 20);
    check_eq("rst_score", score, 0);
    check_eq("rst_combo", combo_count, 0);
    check_eq("rst_cen", combo_enable, 0);
    rst_n = 1'b1;
    tick();
    check_eq("game_after_reset", state, 0);

    // LFSR 45,27,55,46,... -> codes (mod 4) 11,13,13,12,11,13,12,10,11,13,12,11,12
    //                      -> codes (mod 10) 15,17,15,16,...
    beat(4'b0000, 4'b0000, 4'b0000);
`ifdef DOUBLE_ARROW_EN
    check_eq("b1_a0", a0, 15);
`else
    check_eq("b1_a0", a0, 11);
`endif
    check_eq("b1_a3", a3, 20);
    beat(4'b0000, 4'b0000, 4'b0000);
    beat(4'b0000, 4'b0000, 4'b0000);
    check_eq("b3_a3", a3, 20);
`ifdef DOUBLE_ARROW_EN
    check_eq("b3_a2", a2, 15);
    check_eq("b3_a1", a1, 17);
`else
    check_eq("b3_a2", a2, 11);
    check_eq("b3_a1", a1, 13);
`endif
    beat(4'b0000, 4'b0000, 4'b0000);
    check_eq("b4_score", score, 0);
    check_eq("b4_combo", combo_count, 0);

`ifdef DOUBLE_ARROW_EN
    check_eq("b4_a3", a3, 15);
    check_eq("b4_a0", a0, 16);
    beat(4'b0001, 4'b0100, 4'b0000);     // UP then LEFT on 15
    check_eq("dbl_hit_score", score, 1);
    check_eq("dbl_hit_combo", combo_count, 1);
    check_eq("b5_a3", a3, 17);
    beat(4'b0010, 4'b0000, 4'b0000);     // DOWN only on DOWN_LEFT
    check_eq("dbl_miss_score", score, 1);
    check_eq("dbl_miss_combo", combo_count, 0);
    exp_a3 = 15;
    exp_score = 1;
`else
    check_eq("b4_a3", a3, 11);
    check_eq("b4_a0", a0, 12);
    beat(4'b0010, 4'b0000, 4'b0000);
    check_eq("b5_score", score, 1);
    check_eq("b5_combo", combo_count, 1);
    check_eq("b5_a3", a3, 13);
    beat(4'b1000, 4'b0001, 4'b0000);     // extra direction
    check_eq("b6_extra_score", score, 1);
    check_eq("b6_extra_combo", combo_count, 0);
    beat(4'b0000, 4'b0000, 4'b1000);     // press in the beat cycle
    check_eq("b7_samecyc_score", score, 2);
    check_eq("b7_samecyc_combo", combo_count, 1);
    check_eq("b7_a3", a3, 12);
    beat(4'b0000, 4'b0100, 4'b0000);
    check_eq("b8_combo", combo_count, 2);
    beat(4'b0000, 4'b0000, 4'b0000);     // no press
    check_eq("b9_score", score, 3);
    check_eq("b9_combo", combo_count, 0);
    beat(4'b1000, 4'b0000, 4'b0000);
    beat(4'b0100, 4'b0000, 4'b0000);
    check_eq("b11_a3", a3, 10);
    beat(4'b0001, 4'b0000, 4'b0000);     // UP on arrow 10
    check_eq("b12_score", score, 6);
    check_eq("b12_combo", combo_count, 3);
    beat(4'b0000, 4'b0000, 4'b0000);
    check_eq("b13_score", score, 6);
    check_eq("b13_combo", combo_count, 0);
    check_eq("b13_a0", a0, 12);
    exp_a3 = 13;
    exp_score = 6;
`endif
    check_eq("pre_pause_a3", a3, exp_a3);

    pause_req = 1'b1; tick(); pause_req = 1'b0;
    check_eq("pause_state", state, 1);
    beat(4'b0000, 4'b0000, 4'b0000);
    check_eq("pause_frozen_a3", a3, exp_a3);
    check_eq("pause_frozen_score", score, exp_score);
    btn = 4'b0100; tick(); btn = 4'b0000;
    check_eq("pause_cen_on", combo_enable, 1);
    btn = 4'b0001; tick(); btn = 4'b0000;
    check_eq("pause_cen_off", combo_enable, 0);
    btn = 4'b1000; tick(); btn = 4'b0000;
    check_eq("pause_cen_on2", combo_enable, 1);
    pause_req = 1'b1; tick(); pause_req = 1'b0;
    check_eq("unpause_state", state, 0);
    check_eq("unpause_cen", combo_enable, 0);

    // reset_req together with pause_req in the beat cycle
    metronome_clk = 1'b1; tick(); tick();
    metronome_clk = 1'b0; tick();
    reset_req = 1'b1; pause_req = 1'b1; tick();
    reset_req = 1'b0; pause_req = 1'b0;
    check_eq("rreq_state", state, 2);
    check_eq("rreq_a0", a0, 20);
    check_eq("rreq_a3", a3, 20);
    check_eq("rreq_score", score, 0);
    check_eq("rreq_combo", combo_count, 0);
    pause_req = 1'b1; tick(); pause_req = 1'b0;   // ignored while in RESET
    check_eq("rreq_then_game", state, 0);
    tick();
    check_eq("rreq_stays_game", state, 0);

    // Hit every arrow until the counters reach the limit.
    for (int i = 0; i < 10010 && hits < 9999; i++) begin
      p = tb_dir(a3);
      if (p != 4'b0000) hits++;
      beat(p, 4'b0000, 4'b0000);
    end
    check_eq("sat_hits_reached", hits, 9999);
    check_eq("sat_score", score, 9999);
    check_eq("sat_combo", combo_count, 9999);
    p = tb_dir(a3);
    beat(p, 4'b0000, 4'b0000);
    check_eq("sat_hold_score", score, 9999);
    check_eq("sat_hold_combo", combo_count, 9999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
